mant_div_seq: RTL

Sequential radix-2 restoring divider for floating-point mantissas. It is the divide-side counterpart of the multiplier datapath. It accepts a dividend/divisor pair over a valid/ready handshake and retires one quotient bit per cycle, MSB first. It returns a WIDTH+2-bit quotient plus sticky and exception flags to the FPU normalise/round stage.

---
 rtl/mant_div_seq_pkg.sv | 15 +
 rtl/div_sub_step.sv | 19 +
 rtl/mant_div_seq.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/mant_div_seq_pkg.sv
// Shared FPU mantissa-divider definitions.
// Holds the default mantissa width (hidden bit included), the derived
// quotient width, and the state type used by the sequential divider.
package mant_div_seq_pkg;

  localparam int MANT_W = 24;
  localparam int QUOT_W = MANT_W + 2;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } div_state_t;

endpackage

// File: rtl/div_sub_step.sv
// One trial-subtract step of the restoring divider.
// Ports:
//   a      - partial remainder (W bits)
//   b      - zero-extended divisor (W bits)
//   diff   - a - b, modulo 2^W
//   borrow - 1 when b > a; the quotient bit for this step is ~borrow
module div_sub_step #(
  parameter int W = 25
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] diff,
  output logic         borrow
);

  // An extra top bit on both operands captures the borrow out.
  assign {borrow, diff} = {1'b0, a} - {1'b0, b};

endmodule

// File: rtl/mant_div_seq.sv
// Sequential radix-2 restoring divider for floating-point mantissas.
// Produces floor(dividend * 2^(WIDTH+1) / divisor) one bit per cycle,
// MSB (integer bit) first.
// Ports:
//   clk, rst            - clock, asynchronous active-high reset
//   in_valid / in_ready - operand handshake (dividend, divisor)
//   out_valid/out_ready - result handshake
//   quotient            - WIDTH+2 bit quotient, bit WIDTH+1 is the integer bit
//   sticky              - final remainder was nonzero
//   ovf                 - dividend >= 2*divisor (quotient saturated to all ones)
//   dbz                 - divisor was zero (quotient saturated to all ones)
module mant_div_seq
  import mant_div_seq_pkg::*;
#(
  parameter int WIDTH = MANT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH+1:0] quotient,
  output logic             sticky,
  output logic             ovf,
  output logic             dbz
);

  localparam int CNT_W = $clog2(WIDTH + 2);
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH + 1);

  div_state_t       state;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH:0]   rem;
  logic [WIDTH-1:0] dsr;
  logic [WIDTH+1:0] qsr;
  logic             ovf_seen;
  logic             dbz_pend;

  logic [WIDTH:0]   diff;
  logic [WIDTH:0]   rem_next;
  logic             borrow;
  logic             q_bit;
  logic             ovf_now;
  logic [WIDTH+1:0] q_shift;

  div_sub_step #(
    .W(WIDTH + 1)
  ) u_sub (
    .a      (rem),
    .b      ({1'b0, dsr}),
    .diff   (diff),
    .borrow (borrow)
  );

  // Restoring step: keep the difference only when it did not go negative.
  assign q_bit    = ~borrow;
  assign rem_next = q_bit ? diff : rem;
  assign q_shift  = {qsr[WIDTH:0], q_bit};

  // Only the integer-bit step can reveal that the quotient needs a second
  // integer bit; every later step keeps rem_next below the divisor.
  assign ovf_now = (cnt == LAST_STEP) && (rem_next >= {1'b0, dsr});

  // Control FSM plus datapath registers. A zero divisor still passes
  // through BUSY for one cycle so its result appears one edge after
  // acceptance; after a non-overflow step rem_next < divisor < 2^WIDTH,
  // so dropping its top bit in the shift loses nothing.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      rem       <= '0;
      dsr       <= '0;
      qsr       <= '0;
      ovf_seen  <= 1'b0;
      dbz_pend  <= 1'b0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      quotient  <= '0;
      sticky    <= 1'b0;
      ovf       <= 1'b0;
      dbz       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            dsr      <= divisor;
            rem      <= {1'b0, dividend};
            cnt      <= LAST_STEP;
            qsr      <= '0;
            ovf_seen <= 1'b0;
            dbz_pend <= (divisor == '0);
            in_ready <= 1'b0;
            state    <= BUSY;
          end
        end

        BUSY: begin
          if (dbz_pend) begin
            quotient  <= '1;
            sticky    <= 1'b0;
            ovf       <= 1'b0;
            dbz       <= 1'b1;
            out_valid <= 1'b1;
            state     <= DONE;
          end else begin
            qsr <= q_shift;
            if (ovf_now) begin
              ovf_seen <= 1'b1;
            end
            if (cnt != '0) begin
              rem <= {rem_next[WIDTH-1:0], 1'b0};
              cnt <= cnt - 1'b1;
            end else begin
              if (ovf_seen) begin
                quotient <= '1;
                sticky   <= 1'b1;
                ovf      <= 1'b1;
              end else begin
                quotient <= q_shift;
                sticky   <= (rem_next != '0);
                ovf      <= 1'b0;
              end
              dbz       <= 1'b0;
              out_valid <= 1'b1;
              state     <= DONE;
            end
          end
        end

        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
